// File: rtl/timer_bank.sv
// timer_bank: NCH independent tick timers sharing one free-running prescaler.
// The one-shot and periodic modes are always built; define TIMER_BANK_PAUSE_EN to add the PAUSE state.
module timer_bank #(
  parameter int NCH   = 3,
  parameter int CW    = 3,
  parameter int PRESC = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NCH-1:0]    EN,
  input  logic [NCH-1:0]    CLR,
  input  logic [NCH-1:0]    MODE,
  input  logic [NCH*CW-1:0] LIMIT,
  output logic [NCH*CW-1:0] COUNT,
  output logic [NCH-1:0]    DONE,
  output logic [NCH-1:0]    DONE_P,
  output logic              BUSY
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

`ifdef TIMER_BANK_PAUSE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_PAUSE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
`endif

  logic [PW-1:0]  presc_q;
  logic           tick;
  logic [NCH-1:0] busy_q;

  assign tick = (presc_q == PW'(PRESC - 1));

  // The prescaler free-runs; channel starts and stops never realign it.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)    presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + PW'(1);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   lim_q;
    logic            mode_q;
    logic            done_q;
    logic            pulse_q;
    logic [CW-1:0]   limit_in;
    logic            last;

    assign limit_in = LIMIT[i*CW +: CW];
    // Compare one bit wider so an all-ones count plus one cannot wrap past the limit.
    assign last = (({1'b0, cnt_q} + (CW+1)'(1)) >= {1'b0, lim_q});

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        lim_q     <= CW'(1);
        mode_q    <= 1'b0;
        done_q    <= 1'b0;
        pulse_q   <= 1'b0;
        busy_q[i] <= 1'b0;
      end else if (CLR[i]) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        done_q    <= 1'b0;
        pulse_q   <= 1'b0;
        busy_q[i] <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        case (state_q)
          S_IDLE: if (EN[i]) begin
            state_q   <= S_RUN;
            lim_q     <= (limit_in == '0) ? CW'(1) : limit_in;
            mode_q    <= MODE[i];
            busy_q[i] <= 1'b1;
          end
          S_RUN: if (!EN[i]) begin
`ifdef TIMER_BANK_PAUSE_EN
            state_q   <= S_PAUSE;
`else
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q[i] <= 1'b0;
`endif
          end else if (tick) begin
            if (last) begin
              pulse_q <= 1'b1;
              if (mode_q) begin
                cnt_q <= '0;
              end else begin
                state_q   <= S_DONE;
                cnt_q     <= lim_q;
                done_q    <= 1'b1;
                busy_q[i] <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
`ifdef TIMER_BANK_PAUSE_EN
          S_PAUSE: if (EN[i]) state_q <= S_RUN;
`endif
          S_DONE: if (!EN[i]) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end

    assign COUNT[i*CW +: CW] = cnt_q;
    assign DONE[i]           = done_q;
    assign DONE_P[i]         = pulse_q;
  end

  assign BUSY = |busy_q;

endmodule
